// File: rtl/fpu_dispatch.sv
// fpu_dispatch
// In-order issue/retire front end for a bank of variable-latency FPU units.
// Requests carry an op code that selects one execution unit; the unit is
// started with a one-cycle pulse and its result is written back into a
// circular in-flight queue. Results leave through the response port strictly
// in issue order. Op codes with no attached unit complete immediately with an
// error flag and a zero result.
//
// Ports
//   clk, rstn                          clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake
//   req_op, req_x1, req_x2, req_tag    target unit, operands, caller tag
//   unit_start                         one-hot start pulse to the unit bank
//   unit_x1, unit_x2                   operands, meaningful only with unit_start
//   unit_done, unit_y32, unit_y1       per-unit completion pulse and results
//   rsp_valid/rsp_ready                response handshake (head of queue)
//   rsp_y32, rsp_y1, rsp_tag, rsp_err  head entry contents
module fpu_dispatch #(
    parameter int OP_WIDTH  = 5,
    parameter int N_UNITS   = 14,
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OP_WIDTH-1:0]    req_op,
    input  logic [31:0]            req_x1,
    input  logic [31:0]            req_x2,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic [N_UNITS-1:0]     unit_start,
    output logic [31:0]            unit_x1,
    output logic [31:0]            unit_x2,
    input  logic [N_UNITS-1:0]     unit_done,
    input  logic [N_UNITS*32-1:0]  unit_y32,
    input  logic [N_UNITS-1:0]     unit_y1,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_y32,
    output logic                   rsp_y1,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    output logic                   rsp_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    // One extra bit so N_UNITS == 2**OP_WIDTH is still representable.
    localparam logic [OP_WIDTH:0] UNIT_LIMIT = (OP_WIDTH + 1)'(N_UNITS);

    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    logic [TAG_WIDTH-1:0] ent_tag [DEPTH];
    logic [31:0]          ent_y32 [DEPTH];
    logic [DEPTH-1:0]     ent_done;
    logic [DEPTH-1:0]     ent_err;
    logic [DEPTH-1:0]     ent_y1;

    logic [N_UNITS-1:0]   busy;
    logic [N_UNITS-1:0]   busy_next;
    logic [PTR_W-1:0]     ptr [N_UNITS];

    logic                 op_legal;
    logic                 op_busy;
    logic [N_UNITS-1:0]   op_onehot;
    logic [N_UNITS-1:0]   done_hit;
    logic                 accept;
    logic                 start_unit;
    logic                 pop;

    // Decode the requested op into a one-hot unit select and look up whether
    // that unit already holds an operation. Illegal codes match no unit.
    always_comb begin
        op_onehot = '0;
        op_busy   = 1'b0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (req_op == OP_WIDTH'(i)) begin
                op_onehot[i] = 1'b1;
                op_busy      = busy[i];
            end
        end
    end

    assign op_legal   = {1'b0, req_op} < UNIT_LIMIT;
    // Readiness looks only at the current count: a pop in the same cycle
    // does not free a slot for a simultaneous push.
    assign req_ready  = (count < FULL_COUNT) && (!op_legal || !op_busy);
    assign accept     = req_valid && req_ready;
    assign start_unit = accept && op_legal;

    assign rsp_valid  = (count != '0) && ent_done[head];
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_y32    = ent_y32[head];
    assign rsp_y1     = ent_y1[head];
    assign rsp_tag    = ent_tag[head];
    assign rsp_err    = ent_err[head];

    // Done pulses from idle units (stale or spurious) are masked here, so
    // they never touch the queue.
    assign done_hit   = unit_done & busy;
    assign busy_next  = (busy & ~done_hit) | (start_unit ? op_onehot : '0);

    // Start pulse and operands are registered and held for exactly one
    // cycle; operands return to zero otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            unit_start <= '0;
            unit_x1    <= '0;
            unit_x2    <= '0;
        end else if (start_unit) begin
            unit_start <= op_onehot;
            unit_x1    <= req_x1;
            unit_x2    <= req_x2;
        end else begin
            unit_start <= '0;
            unit_x1    <= '0;
            unit_x2    <= '0;
        end
    end

    // In-flight queue: completions land in the entry their unit was bound to,
    // new requests are written at the tail, responses leave from the head.
    // A completing entry can never be the tail slot, so both writes coexist.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            busy     <= '0;
            ent_done <= '0;
            ent_err  <= '0;
            ent_y1   <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                ent_tag[d] <= '0;
                ent_y32[d] <= '0;
            end
            for (int u = 0; u < N_UNITS; u++) begin
                ptr[u] <= '0;
            end
        end else begin
            busy <= busy_next;

            for (int i = 0; i < N_UNITS; i++) begin
                if (done_hit[i]) begin
                    ent_y32[ptr[i]]  <= unit_y32[32*i +: 32];
                    ent_y1[ptr[i]]   <= unit_y1[i];
                    ent_done[ptr[i]] <= 1'b1;
                end
                if (start_unit && op_onehot[i]) begin
                    ptr[i] <= tail;
                end
            end

            if (accept) begin
                ent_tag[tail]  <= req_tag;
                ent_done[tail] <= !op_legal;
                ent_err[tail]  <= !op_legal;
                ent_y32[tail]  <= '0;
                ent_y1[tail]   <= 1'b0;
                tail           <= tail + 1'b1;
            end

            if (pop) begin
                head <= head + 1'b1;
            end

            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/fpu_dispatch.md
# fpu_dispatch

Parametrised FPU issue/retire block: accepts tagged floating-point operations, starts the addressed execution unit with a one-cycle pulse, and returns results strictly in issue order through a ready/valid response port. Up to DEPTH operations are in flight across different units at once; each unit holds at most one operation. It sits between the core's FP issue stage and the bank of variable-latency FPU units (fadd, fmul, finv, ...), which attach through vectorised start/done ports.

## Interface
- OP_WIDTH, 5, width of operation code; code value = unit index
- N_UNITS, 14, number of attached execution units (≤ 2^OP_WIDTH)
- DEPTH, 4, in-flight queue entries; power of two, ≥ 2
- TAG_WIDTH, 4, width of caller tag returned with each result
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  OP_WIDTH  target unit index
- req_x1, req_x2  in  32  operands
- req_tag  in  TAG_WIDTH  caller tag
- unit_start  out  N_UNITS  one-hot start pulse
- unit_x1, unit_x2  out  32  operands, valid only in the start-pulse cycle
- unit_done  in  N_UNITS  per-unit one-cycle completion pulse
- unit_y32  in  N_UNITS*32  per-unit 32-bit result, unit i at bits [32i+31:32i]
- unit_y1  in  N_UNITS  per-unit 1-bit result (compare units)
- rsp_valid  out  1  head result available
- rsp_ready  in  1  consumer takes result when rsp_valid && rsp_ready
- rsp_y32  out  32  result word
- rsp_y1  out  1  result flag
- rsp_tag  out  TAG_WIDTH  tag of the request
- rsp_err  out  1  request carried an illegal op code (≥ N_UNITS)

## Operation
- State: circular queue (head, tail pointers of log2(DEPTH) bits, count of log2(DEPTH+1) bits); per entry {tag, done, err, y32, y1}; per unit busy bit and entry pointer.
- req_ready = (count < DEPTH) && (req_op ≥ N_UNITS || !busy[req_op]); combinational from state and req_op. No pass-through when full, even if a pop occurs the same cycle.
- Accept, legal op: write entry at tail {tag, done=0, err=0}; set busy[op], ptr[op]=tail; tail++, count++.
- Accept, illegal op: write entry {tag, done=1, err=1, y32=0, y1=0}; no unit started.
- unit_done[i] while busy[i]: capture unit_y32 slice i and unit_y1[i] into entry ptr[i], set done, clear busy[i]. unit_done[i] with busy[i]=0 is ignored.
- Several unit_done bits may be high in one cycle; all are captured.
- rsp_valid = count > 0 && head entry done; rsp_* driven from head entry registers. Pop on rsp_valid && rsp_ready: head++, count--.
- Push and pop in the same cycle: count unchanged, both pointers advance; pointers wrap at DEPTH.
- Reset (any time, including mid-operation): queue empty, all busy cleared, unit_start=0, unit_x1/x2=0, rsp_valid=0, rsp_y32=0, rsp_y1=0, rsp_tag=0, rsp_err=0; in-flight results are dropped and later unit_done pulses are ignored.

## Timing
- Accept in cycle T → unit_start[op] and unit_x1/x2 registered, high in T+1 only.
- unit_done may arrive in T+1 (same cycle as start) or any later cycle; done in cycle D → entry done at D+1 → rsp_valid at D+1 if entry is head.
- Illegal op accepted at T → rsp_valid at T+1 if head.
- Unit i done at D: a new request to unit i is accepted no earlier than D+1 (busy still set in D).
- Back-to-back issue to different units: one accept per cycle, sustained while count < DEPTH.
- Results never reorder: a completed younger entry waits behind an incomplete head.

## Test plan
- Single op: reset, req_op=2, x1=0x3F800000, x2=0x40000000, tag=5; unit 2 done 3 cycles after start with y32=0x40400000 → unit_start=0x0004 for one cycle, rsp_valid 4 cycles after start cycle with y32=0x40400000, tag=5, err=0.
- Reorder: issue op 4 (tag 1, done after 6) then op 0 (tag 2, done after 1) → responses in order tag 1 then tag 2; tag 2 held until tag 1 popped.
- Full: DEPTH=4 ops to units 0–3 with no done and rsp_ready=0 → req_ready=0 for 5th request to unit 5; after one done+pop req_ready returns to 1.
- Busy unit: two back-to-back requests to unit 6 → second stalled until cycle after unit_done[6]; stray unit_done[7] with unit 7 idle causes no response.
- Illegal op: req_op=20, tag=9 → no unit_start, rsp_valid next cycle with err=1, y32=0, tag=9.
- Reset mid-flight: 3 ops outstanding, pulse rstn low → all outputs 0, req_ready=1 after release, late unit_done pulses produce no rsp_valid.
